sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO with its own storage array, pointers and flag logic. It is the one-clock successor to the team's dual-port FIFO memory, for blocks where producer and consumer share a clock. Beyond plain storage it adds:
- full/empty, almost-full/almost-empty and occupancy outputs;
- sticky overflow/underflow error flags;
- a synchronous flush;
- a choice of registered read or first-word-fall-through (FWFT) read.

## Interface
Parameters:
- DATASIZE, 8: data word width.
- ADDRSIZE, 4: address bits; DEPTH = 1<<ADDRSIZE.
- AFULL_THRESH, DEPTH-2: almostfull asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almostempty asserts when count <= this value; legal range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = registered read; 1 = first-word-fall-through.

Ports:
- clk, input, 1: single clock for everything; rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of pointers, count and error flags.
- winc, input, 1: write request.
- wdata, input, DATASIZE: write data.
- rinc, input, 1: read request (a pop in FWFT mode).
- rdata, output, DATASIZE: read data.
- rvalid, output, 1: rdata valid. Used in registered mode; in FWFT mode it equals !rempty.
- wfull, output, 1: FIFO holds DEPTH words.
- rempty, output, 1: FIFO holds 0 words.
- almostfull, output, 1: count >= AFULL_THRESH.
- almostempty, output, 1: count <= AEMPTY_THRESH.
- count, output, ADDRSIZE+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; set by a write attempt while full.
- underflow, output, 1: sticky; set by a read attempt while empty.

## Operation
- Storage: reg array [0:DEPTH-1] of DATASIZE bits. The array is not reset and is not cleared by flush.
- Pointers: wptr and rptr, each ADDRSIZE+1 bits binary.
  - The low ADDRSIZE bits address the array.
  - The MSB is the wrap bit.
  - Both increment modulo 2^(ADDRSIZE+1).
- Flags are derived from the registered pointers:
  - count = wptr - rptr, modulo 2^(ADDRSIZE+1).
  - wfull = (count == DEPTH).
  - rempty = (count == 0).
  - almostfull and almostempty decode from count.
  - Flags are combinational from registers, so they carry no extra latency.
- Write acceptance: wr_ok = winc & !wfull & !flush. On wr_ok, mem[wptr] <= wdata and wptr increments.
- Read acceptance: rd_ok = rinc & !rempty & !flush. On rd_ok, rptr increments.
- Simultaneous events:
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
  - When neither full nor empty, a simultaneous write and read are both accepted and count is unchanged.
- Error flags:
  - overflow <= 1 on winc & wfull & !flush.
  - underflow <= 1 on rinc & rempty & !flush.
  - Both stay set until flush or reset.
- flush has priority over winc and rinc. It clears wptr, rptr, overflow, underflow and rvalid; rdata holds its value.
- Registered mode (FWFT=0):
  - On rd_ok, rdata <= mem[rptr[ADDRSIZE-1:0]] and rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr[ADDRSIZE-1:0]], combinational.
  - rdata is meaningful whenever rempty=0.
  - rinc with rempty=0 pops the current head word.

## Timing
- Reset values (rst_n low, asynchronous): pointers 0, count 0, rempty 1, wfull 0, almostempty 1, almostfull 0, overflow 0, underflow 0, rvalid 0. In registered mode rdata is 0.
- Write to read visibility:
  - A write accepted at edge N clears rempty and raises count from edge N.
  - In FWFT mode the word appears on rdata in the cycle after edge N.
- Registered read latency: rinc sampled at edge N gives rdata/rvalid valid after edge N, i.e. one cycle.
- FWFT read latency: zero. The next head word, or rempty=1, is presented after the popping edge.
- Wrap-around: after 2^(ADDRSIZE+1) operations a pointer returns to 0. count stays correct through the wrap.
- Reset deasserting mid-operation needs no special handling; normal operation resumes at the first edge after release.

## Test plan
DEPTH=16, DATASIZE=8, AFULL_THRESH=14, AEMPTY_THRESH=2 throughout.
- Reset check: with rst_n low, all outputs take their reset values. Release reset, then write 0x01..0x03 over three cycles -> count=3, rempty=0, almostempty=0 after the third write.
- Fill to capacity: write 16 words 0xA0..0xAF -> almostfull from the 14th write, wfull=1 and count=16 after the 16th. A 17th winc -> overflow=1 and memory unchanged. Then read 16 words -> 0xA0..0xAF in order, rempty=1.
- Underflow: rinc while empty -> underflow=1, count stays 0. Then flush -> underflow=0 and overflow=0.
- Simultaneous write and read:
  - At count=8, winc and rinc for 20 cycles -> count stays 8 and data order is preserved across the pointer wrap.
  - At count=16, winc and rinc together -> only the read is accepted, count=15.
- FWFT=1: write 0x5A into an empty FIFO -> rdata=0x5A the next cycle with no rinc. Assert rinc -> rempty=1 the next cycle.
- Flush mid-stream: at count=5, drive flush, winc and rinc together -> count=0, rempty=1, nothing written. A subsequent write/read of 0x33 returns 0x33.

Source files
------------

// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if
//   Bundles the producer/consumer side of sync_fifo: write and read requests,
//   data, flush and every status output. clk and rst_n are not part of it.
//
//   master : the user of the FIFO (drives requests, observes status)
//   slave  : the FIFO itself
//
//   flush        synchronous clear of pointers, count and error flags
//   winc/wdata   write request and data
//   rinc         read request (pop in first-word-fall-through mode)
//   rdata/rvalid read data and its qualifier
//   wfull/rempty full and empty flags
//   almostfull/almostempty   threshold flags decoded from count
//   count        occupancy, 0..DEPTH
//   overflow/underflow       sticky error flags
// -----------------------------------------------------------------------------
interface sync_fifo_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
);
   logic                flush;
   logic                winc;
   logic [DATASIZE-1:0] wdata;
   logic                rinc;
   logic [DATASIZE-1:0] rdata;
   logic                rvalid;
   logic                wfull;
   logic                rempty;
   logic                almostfull;
   logic                almostempty;
   logic [ADDRSIZE:0]   count;
   logic                overflow;
   logic                underflow;

   modport master (
      output flush, winc, wdata, rinc,
      input  rdata, rvalid, wfull, rempty, almostfull, almostempty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, winc, wdata, rinc,
      output rdata, rvalid, wfull, rempty, almostfull, almostempty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with its own storage array, binary pointers carrying a
//   wrap bit, occupancy and threshold flags, sticky overflow/underflow, a
//   synchronous flush, and either a registered read (FWFT=0) or a
//   first-word-fall-through read (FWFT=1).
//
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   bus    sync_fifo_if.slave: requests, data and status (see the interface)
//
//   Parameters: DATASIZE word width, ADDRSIZE address bits (DEPTH = 1<<ADDRSIZE),
//   AFULL_THRESH (count >= thresh), AEMPTY_THRESH (count <= thresh), FWFT mode.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATASIZE      = 8,
   parameter int ADDRSIZE      = 4,
   parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input logic        clk,
   input logic        rst_n,
   sync_fifo_if.slave bus
);

   localparam int DEPTH = 1 << ADDRSIZE;

   typedef logic [ADDRSIZE:0]   ptr_t;
   typedef logic [DATASIZE-1:0] word_t;

   // Thresholds and depth as pointer-width constants; AFULL_THRESH may equal
   // DEPTH, which needs the extra bit.
   localparam ptr_t DEPTH_C  = ptr_t'(DEPTH);
   localparam ptr_t AFULL_C  = ptr_t'(AFULL_THRESH);
   localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_THRESH);
   localparam ptr_t ONE_C    = ptr_t'(1);

   word_t mem [0:DEPTH-1];

   ptr_t  wptr_q, wptr_d;
   ptr_t  rptr_q, rptr_d;
   logic  overflow_q, overflow_d;
   logic  underflow_q, underflow_d;

   ptr_t                count;
   logic                wfull;
   logic                rempty;
   logic                wr_ok;
   logic                rd_ok;
   logic [ADDRSIZE-1:0] waddr;
   logic [ADDRSIZE-1:0] raddr;

   // ---------------------------------------------------------------------------
   // Flags: purely combinational from the pointer registers. Because the
   // pointers carry a wrap bit, the modulo difference distinguishes full
   // (DEPTH) from empty (0) without any extra state.
   // ---------------------------------------------------------------------------
   assign count  = wptr_q - rptr_q;
   assign wfull  = (count == DEPTH_C);
   assign rempty = (count == '0);
   assign waddr  = wptr_q[ADDRSIZE-1:0];
   assign raddr  = rptr_q[ADDRSIZE-1:0];

   // The full/empty gate is on the current state only: a read in the same
   // cycle does not make room for a write when full, and vice versa.
   assign wr_ok = bus.winc & ~wfull  & ~bus.flush;
   assign rd_ok = bus.rinc & ~rempty & ~bus.flush;

   assign bus.count       = count;
   assign bus.wfull       = wfull;
   assign bus.rempty      = rempty;
   assign bus.almostfull  = (count >= AFULL_C);
   assign bus.almostempty = (count <= AEMPTY_C);
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

   // ---------------------------------------------------------------------------
   // Next-state logic for pointers and sticky error flags. flush wins over
   // both requests.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (bus.flush) begin
         wptr_d      = '0;
         rptr_d      = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_ok) wptr_d = wptr_q + ONE_C;
         if (rd_ok) rptr_d = rptr_q + ONE_C;
         if (bus.winc && wfull)  overflow_d  = 1'b1;
         if (bus.rinc && rempty) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: the storage array has no reset and flush leaves it alone; its
   // contents are only ever observed behind the pointers, so clearing it
   // would cost a reset net on every bit for nothing.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[waddr] <= bus.wdata;
   end

   // ---------------------------------------------------------------------------
   // Read port
   // ---------------------------------------------------------------------------
   if (FWFT != 0) begin : g_fwft
      // Head word is always presented; a pop simply advances rptr.
      assign bus.rdata  = mem[raddr];
      assign bus.rvalid = ~rempty;
   end else begin : g_reg
      word_t rdata_q, rdata_d;
      logic  rvalid_q, rvalid_d;

      // rd_ok already excludes flush, so flush drops rvalid and holds rdata.
      always_comb begin
         rdata_d  = rdata_q;
         rvalid_d = rd_ok;
         if (rd_ok) rdata_d = mem[raddr];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign bus.rdata  = rdata_q;
      assign bus.rvalid = rvalid_q;
   end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Directed bench for sync_fifo with DEPTH=16, DATASIZE=8, AFULL_THRESH=14,
//   AEMPTY_THRESH=2. u_reg runs the registered read mode, u_fwft the
//   first-word-fall-through mode. Inputs change and outputs are sampled on the
//   falling edge; state changes on the rising edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   sync_fifo_if #(.DATASIZE(8), .ADDRSIZE(4)) fr ();
   sync_fifo_if #(.DATASIZE(8), .ADDRSIZE(4)) ff ();

   sync_fifo #(
      .DATASIZE(8), .ADDRSIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)
   ) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (fr)
   );

   sync_fifo #(
      .DATASIZE(8), .ADDRSIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)
   ) u_fwft (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ff)
   );

   task automatic idle_inputs();
      fr.flush = 1'b0; fr.winc = 1'b0; fr.rinc = 1'b0; fr.wdata = '0;
      ff.flush = 1'b0; ff.winc = 1'b0; ff.rinc = 1'b0; ff.wdata = '0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      checks++; if (fr.count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fr.count); end
      checks++; if (fr.rempty !== 1'b1) begin fails++; $display("FAIL reset_rempty: got %b want 1", fr.rempty); end
      checks++; if (fr.wfull !== 1'b0) begin fails++; $display("FAIL reset_wfull: got %b want 0", fr.wfull); end
      checks++; if (fr.almostempty !== 1'b1) begin fails++; $display("FAIL reset_aempty: got %b want 1", fr.almostempty); end
      checks++; if (fr.almostfull !== 1'b0) begin fails++; $display("FAIL reset_afull: got %b want 0", fr.almostfull); end
      checks++; if (fr.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", fr.overflow); end
      checks++; if (fr.underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %b want 0", fr.underflow); end
      checks++; if (fr.rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", fr.rvalid); end
      checks++; if (fr.rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h want 00", fr.rdata); end
      checks++; if (ff.rempty !== 1'b1) begin fails++; $display("FAIL reset_fwft_rempty: got %b want 1", ff.rempty); end
      checks++; if (ff.rvalid !== 1'b0) begin fails++; $display("FAIL reset_fwft_rvalid: got %b want 0", ff.rvalid); end

      @(negedge clk);
      rst_n = 1'b1;
      // Three writes; almostempty holds at count 2 and drops at count 3.
      for (int i = 1; i <= 3; i++) begin
         fr.winc = 1'b1; fr.wdata = 8'(i);
         @(negedge clk);
         checks++; if (fr.count !== 5'(i)) begin fails++; $display("FAIL wr3_count[%0d]: got %0d want %0d", i, fr.count, i); end
         checks++; if (fr.almostempty !== (i <= 2)) begin fails++; $display("FAIL wr3_aempty[%0d]: got %b want %b", i, fr.almostempty, (i <= 2)); end
      end
      fr.winc = 1'b0;
      checks++; if (fr.rempty !== 1'b0) begin fails++; $display("FAIL wr3_rempty: got %b want 0", fr.rempty); end

      // Registered reads: data one edge after rinc is sampled.
      fr.rinc = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++; if (fr.rdata !== 8'(i)) begin fails++; $display("FAIL rd3_data[%0d]: got %h want %h", i, fr.rdata, 8'(i)); end
         checks++; if (fr.rvalid !== 1'b1) begin fails++; $display("FAIL rd3_rvalid[%0d]: got %b want 1", i, fr.rvalid); end
      end
      fr.rinc = 1'b0;
      @(negedge clk);
      checks++; if (fr.rvalid !== 1'b0) begin fails++; $display("FAIL rd3_rvalid_drop: got %b want 0", fr.rvalid); end
      checks++; if (fr.rdata !== 8'h03) begin fails++; $display("FAIL rd3_rdata_hold: got %h want 03", fr.rdata); end
      checks++; if (fr.rempty !== 1'b1) begin fails++; $display("FAIL rd3_rempty: got %b want 1", fr.rempty); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         fr.winc = 1'b1; fr.wdata = 8'(8'hA0 + i);
         @(negedge clk);
         checks++; if (fr.almostfull !== (i + 1 >= 14)) begin fails++; $display("FAIL fill_afull[%0d]: got %b want %b", i + 1, fr.almostfull, (i + 1 >= 14)); end
         checks++; if (fr.wfull !== (i == 15)) begin fails++; $display("FAIL fill_wfull[%0d]: got %b want %b", i + 1, fr.wfull, (i == 15)); end
      end
      checks++; if (fr.count !== 5'd16) begin fails++; $display("FAIL fill_count: got %0d want 16", fr.count); end
      checks++; if (fr.overflow !== 1'b0) begin fails++; $display("FAIL fill_no_overflow: got %b want 0", fr.overflow); end

      // 17th write attempt is rejected and flagged.
      fr.wdata = 8'hEE;
      @(negedge clk);
      fr.winc = 1'b0;
      checks++; if (fr.overflow !== 1'b1) begin fails++; $display("FAIL fill_overflow: got %b want 1", fr.overflow); end
      checks++; if (fr.count !== 5'd16) begin fails++; $display("FAIL fill_count_after_ovf: got %0d want 16", fr.count); end

      fr.rinc = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++; if (fr.rdata !== 8'(8'hA0 + i)) begin fails++; $display("FAIL fill_rd[%0d]: got %h want %h", i, fr.rdata, 8'(8'hA0 + i)); end
      end
      fr.rinc = 1'b0;
      checks++; if (fr.rempty !== 1'b1) begin fails++; $display("FAIL fill_drain_rempty: got %b want 1", fr.rempty); end
      checks++; if (fr.count !== 5'd0) begin fails++; $display("FAIL fill_drain_count: got %0d want 0", fr.count); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_underflow();
      fr.rinc = 1'b1;
      @(negedge clk);
      fr.rinc = 1'b0;
      checks++; if (fr.underflow !== 1'b1) begin fails++; $display("FAIL udf_flag: got %b want 1", fr.underflow); end
      checks++; if (fr.count !== 5'd0) begin fails++; $display("FAIL udf_count: got %0d want 0", fr.count); end
      checks++; if (fr.rvalid !== 1'b0) begin fails++; $display("FAIL udf_rvalid: got %b want 0", fr.rvalid); end

      fr.flush = 1'b1;
      @(negedge clk);
      fr.flush = 1'b0;
      checks++; if (fr.underflow !== 1'b0) begin fails++; $display("FAIL flush_udf: got %b want 0", fr.underflow); end
      checks++; if (fr.overflow !== 1'b0) begin fails++; $display("FAIL flush_ovf: got %b want 0", fr.overflow); end
      checks++; if (fr.rdata !== 8'hAF) begin fails++; $display("FAIL flush_rdata_hold: got %h want af", fr.rdata); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_simultaneous();
      for (int i = 0; i < 8; i++) begin
         fr.winc = 1'b1; fr.wdata = 8'(8'h10 + i);
         @(negedge clk);
      end
      checks++; if (fr.count !== 5'd8) begin fails++; $display("FAIL sim_prefill: got %0d want 8", fr.count); end

      // 20 concurrent write/read cycles crossing the array wrap.
      fr.rinc = 1'b1;
      for (int i = 0; i < 20; i++) begin
         fr.wdata = 8'(8'h18 + i);
         @(negedge clk);
         checks++; if (fr.count !== 5'd8) begin fails++; $display("FAIL sim_count[%0d]: got %0d want 8", i, fr.count); end
         checks++; if (fr.rdata !== 8'(8'h10 + i)) begin fails++; $display("FAIL sim_data[%0d]: got %h want %h", i, fr.rdata, 8'(8'h10 + i)); end
      end
      fr.rinc = 1'b0;

      // FIFO holds 0x24..0x2B; top up to full with 0x30..0x37.
      for (int i = 0; i < 8; i++) begin
         fr.wdata = 8'(8'h30 + i);
         @(negedge clk);
      end
      checks++; if (fr.wfull !== 1'b1) begin fails++; $display("FAIL sim_full: got %b want 1", fr.wfull); end

      // Full: read accepted, write rejected.
      fr.rinc = 1'b1; fr.wdata = 8'h99;
      @(negedge clk);
      fr.winc = 1'b0; fr.rinc = 1'b0;
      checks++; if (fr.count !== 5'd15) begin fails++; $display("FAIL full_rw_count: got %0d want 15", fr.count); end
      checks++; if (fr.rdata !== 8'h24) begin fails++; $display("FAIL full_rw_data: got %h want 24", fr.rdata); end
      checks++; if (fr.overflow !== 1'b1) begin fails++; $display("FAIL full_rw_ovf: got %b want 1", fr.overflow); end

      // Drain; the pointers also cross the wrap-bit boundary here.
      fr.rinc = 1'b1;
      for (int i = 0; i < 15; i++) begin
         logic [7:0] exp;
         exp = (i < 7) ? 8'(8'h25 + i) : 8'(8'h30 + i - 7);
         @(negedge clk);
         checks++; if (fr.rdata !== exp) begin fails++; $display("FAIL full_drain[%0d]: got %h want %h", i, fr.rdata, exp); end
      end
      fr.rinc = 1'b0;
      checks++; if (fr.rempty !== 1'b1) begin fails++; $display("FAIL full_drain_rempty: got %b want 1", fr.rempty); end

      fr.flush = 1'b1;
      @(negedge clk);
      fr.flush = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_fwft();
      ff.winc = 1'b1; ff.wdata = 8'h5A;
      @(negedge clk);
      ff.winc = 1'b0;
      checks++; if (ff.rdata !== 8'h5A) begin fails++; $display("FAIL fwft_data: got %h want 5a", ff.rdata); end
      checks++; if (ff.rvalid !== 1'b1) begin fails++; $display("FAIL fwft_rvalid: got %b want 1", ff.rvalid); end
      @(negedge clk);
      checks++; if (ff.rdata !== 8'h5A) begin fails++; $display("FAIL fwft_data_hold: got %h want 5a", ff.rdata); end
      ff.rinc = 1'b1;
      @(negedge clk);
      ff.rinc = 1'b0;
      checks++; if (ff.rempty !== 1'b1) begin fails++; $display("FAIL fwft_pop_rempty: got %b want 1", ff.rempty); end
      checks++; if (ff.rvalid !== 1'b0) begin fails++; $display("FAIL fwft_pop_rvalid: got %b want 0", ff.rvalid); end

      // Two words: the second appears right after the first is popped.
      ff.winc = 1'b1; ff.wdata = 8'h11;
      @(negedge clk);
      ff.wdata = 8'h22;
      @(negedge clk);
      ff.winc = 1'b0;
      checks++; if (ff.rdata !== 8'h11) begin fails++; $display("FAIL fwft_head1: got %h want 11", ff.rdata); end
      ff.rinc = 1'b1;
      @(negedge clk);
      ff.rinc = 1'b0;
      checks++; if (ff.rdata !== 8'h22) begin fails++; $display("FAIL fwft_head2: got %h want 22", ff.rdata); end
      checks++; if (ff.count !== 5'd1) begin fails++; $display("FAIL fwft_count: got %0d want 1", ff.count); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_flush_mid();
      for (int i = 0; i < 5; i++) begin
         fr.winc = 1'b1; fr.wdata = 8'(8'h40 + i);
         @(negedge clk);
      end
      checks++; if (fr.count !== 5'd5) begin fails++; $display("FAIL fmid_count5: got %0d want 5", fr.count); end

      fr.flush = 1'b1; fr.winc = 1'b1; fr.rinc = 1'b1; fr.wdata = 8'h77;
      @(negedge clk);
      fr.flush = 1'b0; fr.winc = 1'b0; fr.rinc = 1'b0;
      checks++; if (fr.count !== 5'd0) begin fails++; $display("FAIL fmid_count: got %0d want 0", fr.count); end
      checks++; if (fr.rempty !== 1'b1) begin fails++; $display("FAIL fmid_rempty: got %b want 1", fr.rempty); end
      checks++; if (fr.rvalid !== 1'b0) begin fails++; $display("FAIL fmid_rvalid: got %b want 0", fr.rvalid); end

      fr.winc = 1'b1; fr.wdata = 8'h33;
      @(negedge clk);
      fr.winc = 1'b0;
      checks++; if (fr.count !== 5'd1) begin fails++; $display("FAIL fmid_wr_count: got %0d want 1", fr.count); end
      fr.rinc = 1'b1;
      @(negedge clk);
      fr.rinc = 1'b0;
      checks++; if (fr.rdata !== 8'h33) begin fails++; $display("FAIL fmid_rd_data: got %h want 33", fr.rdata); end
      checks++; if (fr.rvalid !== 1'b1) begin fails++; $display("FAIL fmid_rd_rvalid: got %b want 1", fr.rvalid); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_async_reset();
      fr.winc = 1'b1; fr.wdata = 8'h61;
      @(negedge clk);
      fr.wdata = 8'h62;
      @(negedge clk);
      fr.winc = 1'b0; fr.rinc = 1'b1;
      @(negedge clk);
      fr.rinc = 1'b0;
      // Mid-cycle reset: outputs must clear without waiting for an edge.
      #2 rst_n = 1'b0;
      #1;
      checks++; if (fr.count !== 5'd0) begin fails++; $display("FAIL areset_count: got %0d want 0", fr.count); end
      checks++; if (fr.rdata !== 8'h00) begin fails++; $display("FAIL areset_rdata: got %h want 00", fr.rdata); end
      checks++; if (fr.rvalid !== 1'b0) begin fails++; $display("FAIL areset_rvalid: got %b want 0", fr.rvalid); end
      checks++; if (ff.rempty !== 1'b1) begin fails++; $display("FAIL areset_fwft_rempty: got %b want 1", ff.rempty); end

      @(negedge clk);
      rst_n = 1'b1;
      fr.winc = 1'b1; fr.wdata = 8'h55;
      @(negedge clk);
      fr.winc = 1'b0; fr.rinc = 1'b1;
      @(negedge clk);
      fr.rinc = 1'b0;
      checks++; if (fr.rdata !== 8'h55) begin fails++; $display("FAIL areset_resume: got %h want 55", fr.rdata); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_underflow();
      test_simultaneous();
      test_fwft();
      test_flush_mid();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
